// File: rtl/bitblaster_pkg.sv
// Shared definitions for the BitBlaster 10-bit datapath: ALU function codes,
// sequencer timesteps, instruction classes and IR field positions.
package bitblaster_pkg;

  localparam int DATA_W = 10;
  localparam int NREGS  = 4;
  localparam int IMM_W  = 6;

  // ALU function codes; the ALU decodes the same values.
  typedef enum logic [3:0] {
    FN_LOAD = 4'd0,
    FN_COPY = 4'd1,
    FN_ADD  = 4'd2,
    FN_SUB  = 4'd3,
    FN_INV  = 4'd4,
    FN_FLP  = 4'd5,
    FN_AND  = 4'd6,
    FN_OR   = 4'd7,
    FN_XOR  = 4'd8,
    FN_LSL  = 4'd9,
    FN_LSR  = 4'd10,
    FN_ASR  = 4'd11,
    FN_ADDI = 4'd12,
    FN_SUBI = 4'd13
  } fn_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  typedef enum logic [2:0] {
    CLS_LD     = 3'd0,
    CLS_CP     = 3'd1,
    CLS_UNARY  = 3'd2,
    CLS_BINARY = 3'd3,
    CLS_IMM    = 3'd4,
    CLS_NOP    = 3'd5
  } cls_e;

  localparam int IR_MODE_HI = 9;
  localparam int IR_MODE_LO = 8;
  localparam int IR_X_HI    = 7;
  localparam int IR_X_LO    = 6;
  localparam int IR_Y_HI    = 5;
  localparam int IR_Y_LO    = 4;
  localparam int IR_OP_HI   = 3;
  localparam int IR_OP_LO   = 0;

  localparam logic [1:0] MODE_REG  = 2'b00;
  localparam logic [1:0] MODE_RSVD = 2'b01;
  localparam logic [1:0] MODE_ADDI = 2'b10;
  localparam logic [1:0] MODE_SUBI = 2'b11;

  // Register index to one-hot enable.
  function automatic logic [NREGS-1:0] reg_sel(input logic [1:0] idx);
    logic [NREGS-1:0] one;
    one = {{(NREGS-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode: splits the latched IR into an execution
// class, destination/source register indices and the ALU function code.
module instr_decoder
  import bitblaster_pkg::*;
(
  input  logic [DATA_W-1:0] ir_i,
  output logic [2:0]        cls_o,
  output logic [1:0]        x_o,
  output logic [1:0]        y_o,
  output logic [3:0]        fn_o
);

  logic [1:0] mode_s;
  logic [3:0] op_s;
  cls_e       cls_s;

  assign mode_s = ir_i[IR_MODE_HI:IR_MODE_LO];
  assign op_s   = ir_i[IR_OP_HI:IR_OP_LO];
  assign x_o    = ir_i[IR_X_HI:IR_X_LO];
  assign y_o    = ir_i[IR_Y_HI:IR_Y_LO];
  assign cls_o  = cls_s;

  // Opcode classification; unassigned reg-op codes and the reserved mode are NOPs.
  always_comb begin
    cls_s = CLS_NOP;
    fn_o  = 4'd0;
    case (mode_s)
      MODE_REG: begin
        fn_o = op_s;
        case (op_s)
          4'b0000: cls_s = CLS_LD;
          4'b0001: cls_s = CLS_CP;
          4'b0100,
          4'b0101: cls_s = CLS_UNARY;
          4'b0010, 4'b0011,
          4'b0110, 4'b0111, 4'b1000,
          4'b1001, 4'b1010, 4'b1011: cls_s = CLS_BINARY;
          default: cls_s = CLS_NOP;
        endcase
      end
      MODE_ADDI: begin
        cls_s = CLS_IMM;
        fn_o  = FN_ADDI;
      end
      MODE_SUBI: begin
        cls_s = CLS_IMM;
        fn_o  = FN_SUBI;
      end
      default: begin
        cls_s = CLS_NOP;
        fn_o  = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// BitBlaster sequencer: latches one instruction per EXEC pulse and walks
// timesteps T0..T3, driving the shared-bus and ALU controls from (step, IR).
module control_unit
  import bitblaster_pkg::*;
(
  input  logic              CLKb,
  input  logic              RST,
  input  logic              EXEC,
  input  logic [DATA_W-1:0] INSTR,
  output logic [DATA_W-1:0] IMM,
  output logic [NREGS-1:0]  Rin,
  output logic [NREGS-1:0]  Rout,
  output logic              ExtOut,
  output logic              IMMout,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic [3:0]        FN,
  output logic              Busy,
  output logic              Done
);

  step_e             step_q, step_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [2:0]        cls_raw_s;
  cls_e              cls_s;
  logic [1:0]        x_s, y_s;
  logic [3:0]        fn_s;
  logic [NREGS-1:0]  rin_s;

  instr_decoder u_dec (
    .ir_i  (ir_q),
    .cls_o (cls_raw_s),
    .x_o   (x_s),
    .y_o   (y_s),
    .fn_o  (fn_s)
  );

  assign cls_s = cls_e'(cls_raw_s);
  assign IMM   = {{(DATA_W-IMM_W){1'b0}}, ir_q[IMM_W-1:0]};
  assign Busy  = (step_q != T0);

  // Step counter and IR; everything updates on the CLKb falling edge.
  always_ff @(negedge CLKb) begin
    if (RST) begin
      step_q <= T0;
      ir_q   <= {DATA_W{1'b0}};
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
    end
  end

  // Accept EXEC only while idle; a Done step always returns to T0.
  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    if (step_q == T0) begin
      if (EXEC) begin
        ir_d   = INSTR;
        step_d = T1;
      end else begin
        step_d = T0;
      end
    end else if (Done) begin
      step_d = T0;
    end else begin
      step_d = step_e'(step_q + 2'd1);
    end
  end

  // Per-step control decode; FN is only non-zero alongside Gin.
  always_comb begin
    rin_s  = {NREGS{1'b0}};
    Rout   = {NREGS{1'b0}};
    ExtOut = 1'b0;
    IMMout = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    Gout   = 1'b0;
    FN     = 4'd0;
    Done   = 1'b0;
    case (step_q)
      T1: begin
        case (cls_s)
          CLS_LD: begin
            ExtOut = 1'b1;
            rin_s  = reg_sel(x_s);
            Done   = 1'b1;
          end
          CLS_CP: begin
            Rout  = reg_sel(y_s);
            rin_s = reg_sel(x_s);
            Done  = 1'b1;
          end
          CLS_UNARY: begin
            Rout = reg_sel(y_s);
            FN   = fn_s;
            Gin  = 1'b1;
          end
          CLS_BINARY, CLS_IMM: begin
            Rout = reg_sel(x_s);
            Ain  = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        case (cls_s)
          CLS_UNARY: begin
            Gout  = 1'b1;
            rin_s = reg_sel(x_s);
            Done  = 1'b1;
          end
          CLS_BINARY: begin
            Rout = reg_sel(y_s);
            FN   = fn_s;
            Gin  = 1'b1;
          end
          CLS_IMM: begin
            IMMout = 1'b1;
            FN     = fn_s;
            Gin    = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T3: begin
        case (cls_s)
          CLS_BINARY, CLS_IMM: begin
            Gout  = 1'b1;
            rin_s = reg_sel(x_s);
            Done  = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      default: begin
        Done = 1'b0;
      end
    endcase
    // A reset edge must never also load a register.
    if (RST) begin
      Rin = {NREGS{1'b0}};
    end else begin
      Rin = rin_s;
    end
  end

endmodule
